// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     state_t        - controller states (IDLE, RUN, DONE)
//     DEFAULT_WIDTH  - default operand/result width in bits
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/serial_sub8_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor computing X - Y - Bi.
//   Ports:
//     D  - difference bit
//     Bo - borrow out
//     X  - minuend bit
//     Y  - subtrahend bit
//     Bi - borrow in
// ----------------------------------------------------------------------------
module full_subtractor (
    output logic D,
    output logic Bo,
    input  logic X,
    input  logic Y,
    input  logic Bi
);

    always_comb begin
        D  = X ^ Y ^ Bi;
        Bo = (~X & Y) | (~(X ^ Y) & Bi);
    end

endmodule : full_subtractor

// File: rtl/serial_sub8.sv
// ----------------------------------------------------------------------------
// serial_sub8
//   Bit-serial unsigned subtractor: Diff = A - B - Bin (mod 2^WIDTH),
//   one bit per clock, LSB first. Operands are captured on the edge that
//   accepts start in IDLE; done pulses WIDTH edges later.
//   Optional feature macro: SUB_OVERFLOW_EN (adds signed-overflow output Ovf).
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     start - request pulse, sampled only in IDLE
//     A, B  - minuend / subtrahend (WIDTH bits)
//     Bin   - borrow in
//     Diff  - result, held until the next completion
//     Bout  - borrow out (A < B + Bin, unsigned)
//     busy  - high while in RUN
//     done  - one-cycle pulse when Diff/Bout are freshly loaded
//     Ovf   - signed overflow (only with SUB_OVERFLOW_EN)
// ----------------------------------------------------------------------------
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned    CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    // Minuend shifts out of the LSB while difference bits shift into the MSB,
    // so after WIDTH steps this register holds the complete result.
    logic [WIDTH-1:0] ad_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic             d_bit;
    logic             bo_bit;
    logic             last_bit;

`ifdef SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_fs (
        .D  (d_bit),
        .Bo (bo_bit),
        .X  (ad_sr[0]),
        .Y  (b_sr[0]),
        .Bi (br)
    );

    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)    state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = DONE;
            DONE:               state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: operand capture, per-bit shift, result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ad_sr <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ad_sr <= A;
                        b_sr  <= B;
                        br    <= Bin;
                        cnt   <= '0;
`ifdef SUB_OVERFLOW_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    ad_sr <= {d_bit, ad_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    br    <= bo_bit;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        Diff <= {d_bit, ad_sr[WIDTH-1:1]};
                        Bout <= bo_bit;
`ifdef SUB_OVERFLOW_EN
                        // d_bit is the result MSB on the final step
                        Ovf  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_sub8

// File: tb/tb_serial_sub8.sv
// ----------------------------------------------------------------------------
// tb_serial_sub8
//   Directed bench for serial_sub8 at WIDTH=8 and WIDTH=16.
// ----------------------------------------------------------------------------
module tb_serial_sub8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, bin;
    logic [7:0]  a, b, diff;
    logic        bout, busy, done;

    logic        start16, bin16;
    logic [15:0] a16, b16, diff16;
    logic        bout16, busy16, done16;

`ifdef SUB_OVERFLOW_EN
    logic        ovf, ovf16;
`endif

    int          passed = 0;
    int          total  = 0;
    int unsigned cyc    = 0;
    int unsigned last_done = 0;
    int unsigned last_done16 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    serial_sub8 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .Diff  (diff),
        .Bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf   (ovf)
`endif
    );

    serial_sub8 #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .A     (a16),
        .B     (b16),
        .Bin   (bin16),
        .Diff  (diff16),
        .Bout  (bout16),
        .busy  (busy16),
        .done  (done16)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf   (ovf16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with dut8 in IDLE; returns one cycle after done.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input bit b2b, input logic [7:0] ediff, input logic ebout);
        logic [7:0] held;
        bit         stable;
        int         n, nbusy;
        string      t;
        t      = $sformatf("%02h-%02h-%0d", ia, ib, ibin);
        a      = ia; b = ib; bin = ibin; start = 1'b1;
        held   = diff;
        stable = 1'b1;
        nbusy  = 0;
        @(negedge clk);
        n = 1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        while (!done && n < 40) begin
            if (busy) nbusy++;
            if (diff !== held) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({t, " latency"}, n, 9);
        chk({t, " busy_cycles"}, nbusy, 8);
        chk({t, " hold_during_run"}, stable, 1);
        chk({t, " diff"}, diff, ediff);
        chk({t, " bout"}, bout, ebout);
`ifdef SUB_OVERFLOW_EN
        chk({t, " ovf"}, ovf, (ia[7] ^ ib[7]) & (ia[7] ^ ediff[7]));
`endif
        if (b2b) chk({t, " spacing"}, cyc - last_done, 10);
        last_done = cyc;
        @(negedge clk);
        chk({t, " done_single"}, done, 0);
        chk({t, " idle_busy"}, busy, 0);
    endtask

    task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        input bit b2b);
        logic [16:0] m;
        int          n;
        string       t;
        m  = {1'b0, ia} - {1'b0, ib} - 17'(ibin);
        t  = $sformatf("w16 %04h-%04h-%0d", ia, ib, ibin);
        a16 = ia; b16 = ib; bin16 = ibin; start16 = 1'b1;
        @(negedge clk);
        n = 1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({t, " latency"}, n, 17);
        chk({t, " diff"}, diff16, m[15:0]);
        chk({t, " bout"}, bout16, m[16]);
`ifdef SUB_OVERFLOW_EN
        chk({t, " ovf"}, ovf16, (ia[15] ^ ib[15]) & (ia[15] ^ m[15]));
`endif
        if (b2b) chk({t, " spacing"}, cyc - last_done16, 18);
        last_done16 = cyc;
        @(negedge clk);
        chk({t, " done_single"}, done16, 0);
    endtask

    initial begin
        int         n, ndone;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] m;

        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        #1;
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed directed vectors
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        op8(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0);
        op8(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0);
        op8(8'h77, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0);
        op8(8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1);

        // start held high through RUN with changing operands
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        n = 1;
        a = 8'h11; b = 8'h22; bin = 1'b1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold latency", n, 9);
        chk("hold diff first", diff, 8'h1E);
        chk("hold bout first", bout, 0);
        a = 8'h33; b = 8'h11; bin = 1'b0;
        @(negedge clk);
        n = 1;
        chk("hold single done", done, 0);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold reaccept spacing", n, 10);
        chk("hold diff second", diff, 8'h22);
        start = 1'b0;
        @(negedge clk);

        // Reset asserted at RUN cycle 4
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset diff", diff, 0);
        chk("midrun reset bout", bout, 0);
        chk("midrun reset busy", busy, 0);
        chk("midrun reset done", done, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (done) ndone++;
        end
        chk("no done after reset", ndone, 0);
        op8(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);

        // Random back-to-back, 8-bit
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
            op8(ra, rb, rbin, 1'b1, m[7:0], m[8]);
        end

        // 16-bit instance: boundaries then random back-to-back
        op16(16'h1234, 16'h1234, 1'b0, 1'b0);
        op16(16'h0000, 16'hFFFF, 1'b1, 1'b1);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_serial_sub8

// File: doc/serial_sub8.md
SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits (minimum 2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  WIDTH  minuend; captured when start is accepted.
REQ-006 B  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 Bin  input  1  borrow-in; captured when start is accepted.
REQ-008 Diff  output  WIDTH  result A - B - Bin modulo 2^WIDTH.
REQ-009 Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse marking Diff/Bout valid.
REQ-012 Ovf  output  1  signed overflow; present only when SUB_OVERFLOW_EN is defined.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge SHALL capture A, B and Bin into shift registers, clear the bit counter and enter RUN.
REQ-015 start SHALL be ignored in RUN and DONE; A, B and Bin SHALL be don't-care outside the accepting edge.
REQ-016 Each RUN edge SHALL process one bit, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br); d shifts into the result MSB.
REQ-017 RUN SHALL last exactly WIDTH edges; the edge completing bit WIDTH-1 SHALL load Diff and Bout and enter DONE.
REQ-018 Latency: done SHALL be high in the cycle exactly WIDTH edges after the accepting edge, for exactly one cycle.
REQ-019 DONE SHALL return to IDLE unconditionally on the next edge; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-020 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-021 Diff, Bout (and Ovf) SHALL hold their last result until the next completion; they SHALL NOT change during RUN.
REQ-022 Boundary: A=B with Bin=0 SHALL give Diff=0 and Bout=0; A=0, B=2^WIDTH-1, Bin=1 SHALL give Diff=0 and Bout=1.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, counter=0, and Diff, Bout, busy, done (and Ovf) to 0.
REQ-024 Reset mid-RUN SHALL abandon the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-025 With SUB_OVERFLOW_EN defined, port Ovf SHALL exist and be loaded with (A[MSB] ^ B[MSB]) & (A[MSB] ^ Diff[MSB]) at completion, using the captured operands.
REQ-026 Without SUB_OVERFLOW_EN, Ovf and all its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant (8).
REQ-028 The per-bit stage SHALL be a sub-module full_subtractor (ports D, Bo, X, Y, Bi), instantiated once and reused every cycle.
REQ-029 The counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-030 A=8'h5A, B=8'h3C, Bin=0, start pulse -> done exactly 8 cycles later; Diff=8'h1E, Bout=0, busy high for 8 cycles.
REQ-031 A=8'h00, B=8'h01, Bin=0 -> Diff=8'hFF, Bout=1; A=8'h10, B=8'h0F, Bin=1 -> Diff=8'h00, Bout=0.
REQ-032 With SUB_OVERFLOW_EN: A=8'h80, B=8'h01 -> Diff=8'h7F, Ovf=1; A=8'h05, B=8'h03 -> Ovf=0.
REQ-033 start held high throughout RUN with new operands -> only the first operands are used, a single done pulse, then re-acceptance from IDLE.
REQ-034 rst_n asserted at RUN cycle 4 -> all outputs 0 immediately, no done; next op A=8'hFF, B=8'hFF -> Diff=8'h00, Bout=0.
REQ-035 Randomised back-to-back ops (WIDTH=8 and WIDTH=16) -> every result matches the reference model A-B-Bin, with done spacing of WIDTH+2 cycles.
